// File: rtl/netlist_bist_pkg.sv
// Shared types, default polynomials and next-state helpers for the netlist BIST sequencer.
// Latency: none (types and pure functions). Backpressure: none.
package netlist_bist_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 23;

  localparam logic [IN_W-1:0]  LFSR_POLY_DEF = 16'hB400;
  localparam logic [OUT_W-1:0] MISR_POLY_DEF = 23'h420000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } bist_state_t;

  // Galois shift-right form: the shifted-out bit folds the feedback mask back in.
  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s,
                                                input logic [IN_W-1:0] poly);
    return (s >> 1) ^ (s[0] ? poly : '0);
  endfunction

  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d,
                                                 input logic [OUT_W-1:0] poly);
    return (s >> 1) ^ (s[0] ? poly : '0) ^ d;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Width-generic Galois MISR compactor with synchronous clear and capture enable.
// Latency: 1 cycle per enabled capture. Backpressure: none; clear wins over enable.
module bist_misr #(
  parameter int             W    = 23,
  parameter logic [W-1:0]   POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/netlist_bist_sequencer.sv
// LFSR-pattern / MISR-signature self-test sequencer for one combinational netlist.
// Latency: done NUM_PAT*(SETTLE_CYC+1)+1 cycles after start. Backpressure: start ignored while busy; abort wins.
// Optional trace ports are built when BIST_TRACE_EN is defined.
module netlist_bist_sequencer
  import netlist_bist_pkg::*;
#(
  parameter int                IN_W       = netlist_bist_pkg::IN_W,
  parameter int                OUT_W      = netlist_bist_pkg::OUT_W,
  parameter int                NUM_PAT    = 1024,
  parameter int                SETTLE_CYC = 1,
  parameter logic [IN_W-1:0]   LFSR_POLY  = LFSR_POLY_DEF,
  parameter logic [OUT_W-1:0]  MISR_POLY  = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
`ifdef BIST_TRACE_EN
  ,
  output logic             trace_valid,
  output logic [IN_W-1:0]  trace_pat,
  output logic [OUT_W-1:0] trace_rsp
`endif
);

  bist_state_t     state_q, state_d;
  logic [IN_W-1:0] lfsr_q;
  logic [IN_W-1:0] lfsr_nxt;
  logic [IN_W-1:0] seed_eff;
  logic [15:0]     cnt_q;
  logic [3:0]      settle_q;
  logic            accept;
  logic            last_pat;
  logic            settle_end;

  assign accept     = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_pat   = (cnt_q == 16'(NUM_PAT - 1));
  assign settle_end = (settle_q == 4'(SETTLE_CYC - 1));
  assign seed_eff   = (seed == '0) ? IN_W'(1) : seed;
  assign lfsr_nxt   = lfsr_next(lfsr_q, LFSR_POLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept)     state_d = ST_APPLY;
      ST_APPLY:         if (settle_end) state_d = ST_CAPTURE;
      ST_CAPTURE:       state_d = last_pat ? ST_DONE : ST_APPLY;
      default:          state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // dut_in is loaded together with the LFSR so the pattern is stable for the whole APPLY window.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      dut_in   <= '0;
    end else if (accept) begin
      lfsr_q   <= seed_eff;
      dut_in   <= seed_eff;
      cnt_q    <= '0;
      settle_q <= '0;
    end else if (!abort) begin
      if (state_q == ST_APPLY) begin
        settle_q <= settle_end ? 4'd0 : settle_q + 4'd1;
      end
      if (state_q == ST_CAPTURE) begin
        lfsr_q <= lfsr_nxt;
        cnt_q  <= cnt_q + 16'd1;
        if (!last_pat) dut_in <= lfsr_nxt;
      end
    end
  end

  bist_misr #(
    .W    (OUT_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (abort || accept),
    .en  (state_q == ST_CAPTURE),
    .din (dut_out),
    .q   (signature)
  );

  assign busy = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
  assign done = (state_q == ST_DONE);
  assign pass = done && (signature == golden);

`ifdef BIST_TRACE_EN
  assign trace_valid = (state_q == ST_CAPTURE);
  assign trace_pat   = trace_valid ? dut_in  : '0;
  assign trace_rsp   = trace_valid ? dut_out : '0;
`endif

endmodule
